ddr_burst_arbiter: RTL and testbench

DDR_BURST_ARBITER -- requirements
Module: ddr_burst_arbiter

---
 rtl/ddr_arb_pkg.sv | 20 ++
 rtl/ddr_burst_arbiter_vs_sync.sv | 20 ++
 rtl/ddr_burst_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_ddr_burst_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the DDR burst arbiter.
// Holds the FSM state enum, beat size and address/level widths.
package ddr_arb_pkg;

  localparam int ADDR_W     = 28;
  localparam int DATA_W     = 256;
  localparam int LVL_W      = 9;
  localparam int BEAT_BYTES = 32;
  localparam int BEAT_SH    = $clog2(BEAT_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    W_ADDR,
    W_DATA,
    W_RESP,
    R_ADDR,
    R_DATA
  } state_t;

endpackage

// File: rtl/ddr_burst_arbiter_vs_sync.sv
// vs_sync_edge: 2-flop synchronizer plus rising-edge detect.
// Ports: clk, rst_n (async low), async_in, rise (1-cycle pulse).
module vs_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  // sr[1:0] synchronize, sr[2] is the previous synchronized value
  logic [2:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[1:0], async_in};
  end

  assign rise = sr[1] & ~sr[2];

endmodule

// File: rtl/ddr_burst_arbiter.sv
// Round-robin AXI4 burst arbiter between a write FIFO and a read FIFO
// for a video frame buffer in DDR.
// Ports: ddr_clk/rstn (async low); write FIFO pop side (wfifo_*);
// read FIFO push side (rfifo_*); vs_in/vs_out async frame syncs;
// AXI4 master AW/W/B/AR/R channels with fixed burst length.
// Option: define DDR_PINGPONG_EN for double-buffered frames.
module ddr_burst_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int                BURST_LEN   = 16,
  parameter int                FRAME_BEATS = 64800,
  parameter int                RD_THRESH   = 256 - BURST_LEN,
  parameter logic [ADDR_W-1:0] WR_BASE     = '0,
  parameter logic [ADDR_W-1:0] RD_BASE     = '0
) (
  input  logic              ddr_clk,
  input  logic              rstn,
  input  logic [LVL_W-1:0]  wfifo_rd_water_level,
  output logic              wfifo_rd_req,
  input  logic [DATA_W-1:0] wfifo_rd_data256,
  input  logic [LVL_W-1:0]  rfifo_wr_water_level,
  output logic              rfifo_wr_req,
  output logic [DATA_W-1:0] rfifo_wr_data256,
  input  logic              vs_in,
  input  logic              vs_out,
  output logic [ADDR_W-1:0] awaddr,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        axi_len,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic              wvalid,
  input  logic              wready,
  output logic              wlast,
  input  logic              bvalid,
  output logic              bready,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  input  logic              rlast,
  output logic              rready
);

  localparam int CNT_W = $clog2(BURST_LEN);
  localparam int OFF_W = $clog2(FRAME_BEATS + BURST_LEN + 1);

  localparam logic [LVL_W-1:0]  WR_LVL    = LVL_W'(BURST_LEN);
  localparam logic [LVL_W-1:0]  RD_LVL    = LVL_W'(RD_THRESH);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [OFF_W-1:0]  STEP      = OFF_W'(BURST_LEN);
  localparam logic [OFF_W-1:0]  WRAP      = OFF_W'(FRAME_BEATS);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] beat;
  logic [OFF_W-1:0] wr_off;
  logic [OFF_W-1:0] rd_off;
  logic [OFF_W-1:0] wr_step;
  logic [OFF_W-1:0] rd_step;
  logic             last_wr;
  logic             wr_flag;
  logic             rd_flag;
  logic             vs_in_rise;
  logic             vs_out_rise;
  logic             wr_elig;
  logic             rd_elig;
  logic             wr_apply;
  logic             rd_apply;
  logic             wr_done;
  logic             rd_done;
  logic [ADDR_W-1:0] wr_base_cur;
  logic [ADDR_W-1:0] rd_base_cur;

  vs_sync_edge u_vs_in (
    .clk      (ddr_clk),
    .rst_n    (rstn),
    .async_in (vs_in),
    .rise     (vs_in_rise)
  );

  vs_sync_edge u_vs_out (
    .clk      (ddr_clk),
    .rst_n    (rstn),
    .async_in (vs_out),
    .rise     (vs_out_rise)
  );

  assign wr_elig = wfifo_rd_water_level >= WR_LVL;
  assign rd_elig = rfifo_wr_water_level < RD_LVL;

  always_ff @(posedge ddr_clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    unique case (state)
      IDLE: begin
        // on a tie, serve whichever type did not go last
        if (wr_elig && (!rd_elig || !last_wr))
          state_nxt = W_ADDR;
        else if (rd_elig)
          state_nxt = R_ADDR;
      end
      W_ADDR: begin
        awvalid = 1'b1;
        if (awready) state_nxt = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        if (wready && beat == LAST_BEAT)
          state_nxt = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) state_nxt = IDLE;
      end
      R_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid && rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wfifo_rd_req     = wvalid & wready;
  assign wlast            = wvalid & (beat == LAST_BEAT);
  assign wdata            = wfifo_rd_data256;
  assign rfifo_wr_req     = rready & rvalid;
  assign rfifo_wr_data256 = rdata;
  assign axi_len          = 8'(BURST_LEN - 1);

  always_ff @(posedge ddr_clk or negedge rstn) begin
    if (!rstn) begin
      beat <= '0;
    end else if (wfifo_rd_req) begin
      beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
    end
  end

  // reset value 0 means read went last, so write wins the first tie
  always_ff @(posedge ddr_clk or negedge rstn) begin
    if (!rstn) begin
      last_wr <= 1'b0;
    end else if (state == IDLE) begin
      if (state_nxt == W_ADDR)      last_wr <= 1'b1;
      else if (state_nxt == R_ADDR) last_wr <= 1'b0;
    end
  end

  // restarts only take effect between bursts; an edge landing in the
  // same cycle as the apply re-arms the flag for the next IDLE
  assign wr_apply = (state == IDLE) & wr_flag;
  assign rd_apply = (state == IDLE) & rd_flag;

  always_ff @(posedge ddr_clk or negedge rstn) begin
    if (!rstn) begin
      wr_flag <= 1'b0;
      rd_flag <= 1'b0;
    end else begin
      wr_flag <= vs_in_rise  | (wr_flag & ~wr_apply);
      rd_flag <= vs_out_rise | (rd_flag & ~rd_apply);
    end
  end

  assign wr_done = (state == W_RESP) & bvalid;
  assign rd_done = (state == R_DATA) & rvalid & rlast;
  assign wr_step = wr_off + STEP;
  assign rd_step = rd_off + STEP;

  always_ff @(posedge ddr_clk or negedge rstn) begin
    if (!rstn) begin
      wr_off <= '0;
      rd_off <= '0;
    end else begin
      if (wr_apply)     wr_off <= '0;
      else if (wr_done) wr_off <= (wr_step >= WRAP) ? '0 : wr_step;
      if (rd_apply)     rd_off <= '0;
      else if (rd_done) rd_off <= (rd_step >= WRAP) ? '0 : rd_step;
    end
  end

`ifdef DDR_PINGPONG_EN
  localparam logic [ADDR_W-1:0] FRAME_BYTES =
    ADDR_W'(FRAME_BEATS * BEAT_BYTES);

  logic wr_buf;
  logic rd_buf;
  logic done_buf;

  // done_buf starts on the buffer the writer is not filling, so an
  // early read restart never lands on the frame being written
  always_ff @(posedge ddr_clk or negedge rstn) begin
    if (!rstn) begin
      wr_buf   <= 1'b0;
      rd_buf   <= 1'b0;
      done_buf <= 1'b1;
    end else begin
      if (wr_apply) begin
        wr_buf   <= ~wr_buf;
        done_buf <= wr_buf;
      end
      if (rd_apply)
        rd_buf <= wr_apply ? wr_buf : done_buf;
    end
  end

  assign wr_base_cur = wr_buf ? WR_BASE + FRAME_BYTES : WR_BASE;
  assign rd_base_cur = rd_buf ? RD_BASE + FRAME_BYTES : RD_BASE;
`else
  assign wr_base_cur = WR_BASE;
  assign rd_base_cur = RD_BASE;
`endif

  // addresses come only from registers, so they stay put while valid
  assign awaddr = wr_base_cur + (ADDR_W'(wr_off) << BEAT_SH);
  assign araddr = rd_base_cur + (ADDR_W'(rd_off) << BEAT_SH);

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Directed bench for ddr_burst_arbiter with a 32-beat frame.
// Covers burst sequencing, wrap, restarts, round-robin and reset.
module tb_ddr_burst_arbiter;

  logic         clk;
  logic         rstn;
  logic [8:0]   wlvl;
  logic         wfifo_rd_req;
  logic [255:0] wfd;
  logic [8:0]   rlvl;
  logic         rfifo_wr_req;
  logic [255:0] rfifo_wr_data256;
  logic         vs_in;
  logic         vs_out;
  logic [27:0]  awaddr;
  logic [27:0]  araddr;
  logic [7:0]   axi_len;
  logic         awvalid;
  logic         awready;
  logic [255:0] wdata;
  logic         wvalid;
  logic         wready;
  logic         wlast;
  logic         bvalid;
  logic         bready;
  logic         arvalid;
  logic         arready;
  logic [255:0] rdata;
  logic         rvalid;
  logic         rlast;
  logic         rready;

  int checks = 0;
  int errors = 0;

  ddr_burst_arbiter #(
    .FRAME_BEATS (32)
  ) dut (
    .ddr_clk              (clk),
    .rstn                 (rstn),
    .wfifo_rd_water_level (wlvl),
    .wfifo_rd_req         (wfifo_rd_req),
    .wfifo_rd_data256     (wfd),
    .rfifo_wr_water_level (rlvl),
    .rfifo_wr_req         (rfifo_wr_req),
    .rfifo_wr_data256     (rfifo_wr_data256),
    .vs_in                (vs_in),
    .vs_out               (vs_out),
    .awaddr               (awaddr),
    .araddr               (araddr),
    .axi_len              (axi_len),
    .awvalid              (awvalid),
    .awready              (awready),
    .wdata                (wdata),
    .wvalid               (wvalid),
    .wready               (wready),
    .wlast                (wlast),
    .bvalid               (bvalid),
    .bready               (bready),
    .arvalid              (arvalid),
    .arready              (arready),
    .rdata                (rdata),
    .rvalid               (rvalid),
    .rlast                (rlast),
    .rready               (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr_burst(input logic [27:0] a,
                          input bit tog,
                          input bit vs);
    int g;
    int n;
    g = 0;
    while (!awvalid && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    chk("aw_seen", awvalid, 1);
    chk("awaddr", awaddr, a);
    chk("ar_idle_in_w", arvalid, 0);
    @(posedge clk); #1;
    n = 0;
    g = 0;
    while (n < 16 && g < 100) begin
      if (tog) wready = ~wready;
      else     wready = 1'b1;
      if (vs) vs_in = (n >= 4 && n < 8);
      #1;
      chk("wvalid", wvalid, 1);
      chk("wlast", wlast, n == 15);
      chk("wfifo_rd_req", wfifo_rd_req, wready);
      chk("wdata", wdata, wfd);
      if (wready) n++;
      @(posedge clk); #1;
      g++;
    end
    chk("w_beats", n, 16);
    chk("bready", bready, 1);
    chk("wvalid_resp", wvalid, 0);
    wready = 1'b1;
    vs_in  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rd_burst(input logic [27:0] a, input bit vs);
    int g;
    logic [255:0] exp_d;
    g = 0;
    while (!arvalid && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    chk("ar_seen", arvalid, 1);
    chk("araddr", araddr, a);
    chk("aw_idle_in_r", awvalid, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      exp_d  = {8{32'hA500_0000 + 32'(i)}};
      rvalid = 1'b1;
      rlast  = (i == 15);
      rdata  = exp_d;
      if (vs) vs_out = (i >= 2 && i < 6);
      #1;
      chk("rready", rready, 1);
      chk("rfifo_wr_req", rfifo_wr_req, 1);
      chk("rfifo_data", rfifo_wr_data256, exp_d);
      @(posedge clk); #1;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    vs_out = 1'b0;
    #1;
    chk("rready_done", rready, 0);
  endtask

  initial begin
    rstn    = 1'b0;
    vs_in   = 1'b0;
    vs_out  = 1'b0;
    wlvl    = 9'd16;
    rlvl    = 9'd255;
    awready = 1'b1;
    wready  = 1'b1;
    bvalid  = 1'b1;
    arready = 1'b1;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    rdata   = '0;
    wfd     = {4{64'hDEAD_BEEF_0123_4567}};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awvalid", awvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rready", rready, 0);
    chk("rst_wreq", wfifo_rd_req, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_araddr", araddr, 0);
    chk("axi_len", axi_len, 8'h0f);
    rstn = 1'b1;

    // writes only; 32-beat frame wraps after two bursts
    wr_burst(28'h000, 0, 0);
    wr_burst(28'h200, 0, 0);
    wr_burst(28'h000, 0, 0);
    // wready toggling every cycle
    wr_burst(28'h200, 1, 0);
    // restart during a burst at 0: next would be 0x200 without it
    wr_burst(28'h000, 0, 1);
    wr_burst(28'h000, 0, 0);

    // reset in the middle of a read burst
    wlvl = 9'd0;
    rlvl = 9'd0;
    begin
      int g;
      g = 0;
      while (!arvalid && g < 20) begin
        @(posedge clk); #1;
        g++;
      end
      chk("pre_rst_ar", arvalid, 1);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
        rvalid = 1'b1;
        rdata  = {8{32'h5A00_0000 + 32'(i)}};
        @(posedge clk); #1;
      end
      chk("mid_rready", rready, 1);
      rstn = 1'b0;
      #1;
      chk("arst_rready", rready, 0);
      chk("arst_rreq", rfifo_wr_req, 0);
      chk("arst_arvalid", arvalid, 0);
      chk("arst_awvalid", awvalid, 0);
      chk("arst_wvalid", wvalid, 0);
      rvalid = 1'b0;
      wlvl   = 9'd16;
      @(posedge clk); #1;
      rstn = 1'b1;
    end

    // both eligible: W,R,W,R; read restart mid-burst returns reads to 0
    wr_burst(28'h000, 0, 0);
    rd_burst(28'h000, 1);
    wr_burst(28'h200, 0, 0);
    rd_burst(28'h000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
